// File: rtl/mem_write_checker.sv
// mem_write_checker: snoops a memory-write bus and checks the writes to one watched
// address against a programmed sequence of expected values, with a cycle timeout.
// Results are reported as done/pass plus a failure code and the failing index.
//
// Optional build macro MEMCHK_STRICT_ADR_EN: while running, any write to an address
// other than the watched one fails the run with fail_code 3. When it is undefined,
// such writes are ignored.
//
// fail_code: 0 none, 1 data mismatch / bad length, 2 timeout, 3 stray address.

module mem_write_checker #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NEXP    = 4,
  parameter int unsigned TIMEOUT = 20000,
  parameter int unsigned CNTBITS = 16,
  localparam int unsigned LENW   = $clog2(NEXP + 1),
  localparam int unsigned IDXW   = (NEXP > 1) ? $clog2(NEXP) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      watch_adr,
  input  logic [LENW-1:0]       exp_len,
  input  logic [NEXP*WIDTH-1:0] exp_data,
  input  logic                  memwrite,
  input  logic [WIDTH-1:0]      adr,
  input  logic [WIDTH-1:0]      writedata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code,
  output logic [IDXW-1:0]       fail_index,
  output logic [WIDTH-1:0]      obs_data,
  output logic [CNTBITS-1:0]    write_count
);

  typedef enum logic [2:0] {StIdle, StRun, StPass, StFail, StTout} state_e;

  localparam logic [1:0] CodeNone     = 2'd0;
  localparam logic [1:0] CodeMismatch = 2'd1;
  localparam logic [1:0] CodeTimeout  = 2'd2;
  localparam logic [1:0] CodeStray    = 2'd3;

  state_e                  state_q;
  logic [WIDTH-1:0]        watch_q;
  logic [LENW-1:0]         len_q;
  logic [NEXP*WIDTH-1:0]   exp_q;
  logic [IDXW-1:0]         idx_q;
  logic [CNTBITS-1:0]      timer_q;

  logic [WIDTH-1:0]        exp_cur;
  logic                    checked;
  logic                    is_last;
  logic                    len_bad;
  logic                    timer_hit;

  // Decode the current expected entry and per-cycle qualifiers from latched config.
  always_comb begin
    exp_cur   = exp_q[int'(idx_q) * WIDTH +: WIDTH];
    checked   = memwrite && (adr == watch_q);
    is_last   = (LENW'(idx_q) == (len_q - LENW'(1)));
    len_bad   = (exp_len == '0) || (exp_len > LENW'(NEXP));
    timer_hit = (timer_q == CNTBITS'(TIMEOUT - 1));
  end

  // Checker FSM; all outputs are registered here alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      watch_q     <= '0;
      len_q       <= '0;
      exp_q       <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= CodeNone;
      fail_index  <= '0;
      obs_data    <= '0;
      write_count <= '0;
    end else begin
      case (state_q)
        StIdle, StPass, StFail, StTout: begin
          if (start) begin
            watch_q     <= watch_adr;
            len_q       <= exp_len;
            exp_q       <= exp_data;
            idx_q       <= '0;
            timer_q     <= '0;
            write_count <= '0;
            fail_index  <= '0;
            obs_data    <= '0;
            pass        <= 1'b0;
            if (len_bad) begin
              // An unusable length can never pass; report it as a mismatch at index 0.
              state_q   <= StFail;
              busy      <= 1'b0;
              done      <= 1'b1;
              fail_code <= CodeMismatch;
            end else begin
              state_q   <= StRun;
              busy      <= 1'b1;
              done      <= 1'b0;
              fail_code <= CodeNone;
            end
          end
        end

        StRun: begin
          timer_q <= timer_q + CNTBITS'(1);
          // A checked write outranks a stray write and the timeout in the same cycle.
          if (checked) begin
            obs_data <= writedata;
            if (write_count != '1) begin
              write_count <= write_count + CNTBITS'(1);
            end
            if (writedata == exp_cur) begin
              if (is_last) begin
                state_q <= StPass;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b1;
              end else begin
                idx_q <= idx_q + IDXW'(1);
              end
            end else begin
              state_q    <= StFail;
              busy       <= 1'b0;
              done       <= 1'b1;
              fail_code  <= CodeMismatch;
              fail_index <= idx_q;
            end
          end
`ifdef MEMCHK_STRICT_ADR_EN
          else if (memwrite) begin
            state_q    <= StFail;
            busy       <= 1'b0;
            done       <= 1'b1;
            fail_code  <= CodeStray;
            fail_index <= idx_q;
            obs_data   <= writedata;
          end
`endif
          else if (timer_hit) begin
            state_q    <= StTout;
            busy       <= 1'b0;
            done       <= 1'b1;
            fail_code  <= CodeTimeout;
            fail_index <= idx_q;
          end
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          pass    <= 1'b0;
        end
      endcase
    end
  end

  // Stray-address failures only exist in the strict build.
`ifndef MEMCHK_STRICT_ADR_EN
  logic unused_code;
  assign unused_code = ^CodeStray;
`endif

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed self-checking bench for mem_write_checker (TIMEOUT shortened to 50).

module tb_mem_write_checker;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned NEXP    = 4;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned CNTBITS = 16;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  watch_adr;
  logic [2:0]  exp_len;
  logic [31:0] exp_data;
  logic        memwrite;
  logic [7:0]  adr;
  logic [7:0]  writedata;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [1:0]  fail_index;
  logic [7:0]  obs_data;
  logic [15:0] write_count;

  int checks = 0;
  int errors = 0;

  mem_write_checker #(
    .WIDTH  (WIDTH),
    .NEXP   (NEXP),
    .TIMEOUT(TIMEOUT),
    .CNTBITS(CNTBITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .watch_adr  (watch_adr),
    .exp_len    (exp_len),
    .exp_data   (exp_data),
    .memwrite   (memwrite),
    .adr        (adr),
    .writedata  (writedata),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_code  (fail_code),
    .fail_index (fail_index),
    .obs_data   (obs_data),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_start(input logic [7:0] a, input logic [2:0] len, input logic [31:0] d);
    start     = 1'b1;
    watch_adr = a;
    exp_len   = len;
    exp_data  = d;
    tick();
    start     = 1'b0;
    watch_adr = 8'h00;
    exp_len   = 3'd0;
    exp_data  = 32'h0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    memwrite  = 1'b1;
    adr       = a;
    writedata = d;
    tick();
    memwrite  = 1'b0;
    adr       = 8'h00;
    writedata = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", pass); end
    checks++; if (fail_code !== 2'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", fail_code); end
    checks++; if (obs_data !== 8'h00) begin errors++; $display("FAIL reset_obs: got %h want 00", obs_data); end
    checks++; if (write_count !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", write_count); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_legacy();
    do_start(8'hFF, 3'd1, 32'h0000_000D);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL legacy_busy: got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL legacy_notdone: got %b want 0", done); end
    idle(3);
    wr(8'hFF, 8'h0D);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL legacy_done: got %b want 1", done); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL legacy_pass: got %b want 1", pass); end
    checks++; if (obs_data !== 8'h0D) begin errors++; $display("FAIL legacy_obs: got %h want 0d", obs_data); end
    checks++; if (write_count !== 16'd1) begin errors++; $display("FAIL legacy_cnt: got %0d want 1", write_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL legacy_idle: got %b want 0", busy); end
  endtask

  task automatic test_sequence();
    do_start(8'hFF, 3'd3, 32'h0002_0101);
    wr(8'hFF, 8'h01);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL seq_w1_busy: got busy=%b done=%b want 1 0", busy, done); end
    checks++; if (write_count !== 16'd1) begin errors++; $display("FAIL seq_w1_cnt: got %0d want 1", write_count); end
    wr(8'hFF, 8'h01);
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL seq_w2_busy: got busy=%b done=%b want 1 0", busy, done); end
    wr(8'hFF, 8'h02);
    checks++; if (pass !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL seq_pass: got pass=%b done=%b want 1 1", pass, done); end
    checks++; if (write_count !== 16'd3) begin errors++; $display("FAIL seq_cnt: got %0d want 3", write_count); end
    checks++; if (obs_data !== 8'h02) begin errors++; $display("FAIL seq_obs: got %h want 02", obs_data); end
    idle(2);
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL seq_sticky: got %b want 1", pass); end
  endtask

  task automatic test_mismatch();
    do_start(8'hFF, 3'd3, 32'h0002_0101);
    wr(8'hFF, 8'h01);
    wr(8'hFF, 8'h05);
    checks++; if (done !== 1'b1 || pass !== 1'b0) begin errors++; $display("FAIL mm_done: got done=%b pass=%b want 1 0", done, pass); end
    checks++; if (fail_code !== 2'd1) begin errors++; $display("FAIL mm_code: got %0d want 1", fail_code); end
    checks++; if (fail_index !== 2'd1) begin errors++; $display("FAIL mm_index: got %0d want 1", fail_index); end
    checks++; if (obs_data !== 8'h05) begin errors++; $display("FAIL mm_obs: got %h want 05", obs_data); end
    wr(8'hFF, 8'h02);
    wr(8'hFF, 8'h01);
    checks++; if (obs_data !== 8'h05 || write_count !== 16'd2) begin errors++; $display("FAIL mm_frozen: got obs=%h cnt=%0d want 05 2", obs_data, write_count); end
    checks++; if (fail_code !== 2'd1 || fail_index !== 2'd1) begin errors++; $display("FAIL mm_frozen_code: got %0d/%0d want 1/1", fail_code, fail_index); end
  endtask

  task automatic test_timeout();
    do_start(8'hFF, 3'd1, 32'h0000_0033);
    wr(8'h20, 8'h33);
    idle(48);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tout_early: got busy=%b want 1", busy); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL tout_done: got busy=%b done=%b want 0 1", busy, done); end
    checks++; if (fail_code !== 2'd2) begin errors++; $display("FAIL tout_code: got %0d want 2", fail_code); end
    checks++; if (pass !== 1'b0 || fail_index !== 2'd0) begin errors++; $display("FAIL tout_idx: got pass=%b idx=%0d want 0 0", pass, fail_index); end
    // A checked write on the last RUN cycle wins over the timeout.
    do_start(8'hFF, 3'd1, 32'h0000_0033);
    idle(49);
    wr(8'hFF, 8'h33);
    checks++; if (pass !== 1'b1 || fail_code !== 2'd0) begin errors++; $display("FAIL tout_edge_pass: got pass=%b code=%0d want 1 0", pass, fail_code); end
    do_start(8'hFF, 3'd1, 32'h0000_0033);
    idle(49);
    wr(8'hFF, 8'h34);
    checks++; if (fail_code !== 2'd1 || obs_data !== 8'h34) begin errors++; $display("FAIL tout_edge_fail: got code=%0d obs=%h want 1 34", fail_code, obs_data); end
  endtask

  task automatic test_reset_mid();
    do_start(8'hFF, 3'd3, 32'h0002_0101);
    wr(8'hFF, 8'h01);
    #2;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got %b%b%b want 000", busy, done, pass); end
    checks++; if (write_count !== 16'd0 || obs_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got cnt=%0d obs=%h want 0 00", write_count, obs_data); end
    tick();
    reset = 1'b1;
    tick();
    do_start(8'hFF, 3'd3, 32'h0002_0101);
    wr(8'hFF, 8'h01);
    wr(8'hFF, 8'h01);
    wr(8'hFF, 8'h02);
    checks++; if (pass !== 1'b1 || write_count !== 16'd3) begin errors++; $display("FAIL rstmid_rerun: got pass=%b cnt=%0d want 1 3", pass, write_count); end
  endtask

  task automatic test_strict();
    do_start(8'hFF, 3'd2, 32'h0000_0201);
    wr(8'hFF, 8'h01);
    wr(8'h10, 8'hAA);
`ifdef MEMCHK_STRICT_ADR_EN
    checks++; if (done !== 1'b1 || fail_code !== 2'd3) begin errors++; $display("FAIL strict_code: got done=%b code=%0d want 1 3", done, fail_code); end
    checks++; if (fail_index !== 2'd1 || obs_data !== 8'hAA) begin errors++; $display("FAIL strict_data: got idx=%0d obs=%h want 1 aa", fail_index, obs_data); end
`else
    checks++; if (busy !== 1'b1 || obs_data !== 8'h01) begin errors++; $display("FAIL stray_ignored: got busy=%b obs=%h want 1 01", busy, obs_data); end
    wr(8'hFF, 8'h02);
    checks++; if (pass !== 1'b1 || write_count !== 16'd2) begin errors++; $display("FAIL stray_pass: got pass=%b cnt=%0d want 1 2", pass, write_count); end
`endif
  endtask

  task automatic test_bad_len();
    do_start(8'hFF, 3'd0, 32'h0000_0001);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || fail_code !== 2'd1) begin errors++; $display("FAIL badlen0: got done=%b busy=%b code=%0d want 1 0 1", done, busy, fail_code); end
    do_start(8'hFF, 3'd5, 32'h0000_0001);
    checks++; if (done !== 1'b1 || fail_code !== 2'd1 || fail_index !== 2'd0) begin errors++; $display("FAIL badlen5: got done=%b code=%0d idx=%0d want 1 1 0", done, fail_code, fail_index); end
  endtask

  task automatic test_back_to_back();
    // Held strobe counts once per cycle; a second start in RUN is ignored.
    do_start(8'hFF, 3'd2, 32'h0000_0707);
    do_start(8'hFF, 3'd1, 32'h0000_0022);
    memwrite  = 1'b1;
    adr       = 8'hFF;
    writedata = 8'h07;
    tick();
    checks++; if (busy !== 1'b1 || write_count !== 16'd1) begin errors++; $display("FAIL b2b_first: got busy=%b cnt=%0d want 1 1", busy, write_count); end
    tick();
    memwrite  = 1'b0;
    checks++; if (pass !== 1'b1 || write_count !== 16'd2) begin errors++; $display("FAIL b2b_pass: got pass=%b cnt=%0d want 1 2", pass, write_count); end
  endtask

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    watch_adr = 8'h00;
    exp_len   = 3'd0;
    exp_data  = 32'h0;
    memwrite  = 1'b0;
    adr       = 8'h00;
    writedata = 8'h00;
    #2;
    test_reset();
    test_legacy();
    test_sequence();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    test_strict();
    test_bad_len();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
